// File: rtl/result_queue_read_arbiter.sv
// result_queue_read_arbiter: round-robin share of one non-showahead result-queue read port among N requesters.
// Optional pop statistics counter enabled by defining RQ_ARB_STATS_EN.
module result_queue_read_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         data_wanted,
    output logic [N-1:0]         data_ready,
    output logic [WIDTH-1:0]     data,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    input  logic                 rq_empty,
    output logic                 rq_re,
`ifdef RQ_ARB_STATS_EN
    input  logic [WIDTH-1:0]     rq_q,
    output logic [15:0]          pop_count
`else
    input  logic [WIDTH-1:0]     rq_q
`endif
);
    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPTURE, S_SEND} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, winner;
    logic [WIDTH-1:0] data_q, data_d;
    logic [GW:0]      idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= GW'(N - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    // Scan offsets N..1 so the nearest requester after the last grant is assigned last and wins.
    always_comb begin
        winner = grant_q;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, grant_q} + (GW + 1)'(k);
            idx = (idx >= (GW + 1)'(N)) ? idx - (GW + 1)'(N) : idx;
            if (req[idx[GW-1:0]]) winner = idx[GW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (|req && !rq_empty) begin
                    state_d = S_POP;
                    grant_d = winner;
                end
            end
            S_POP: state_d = S_CAPTURE;
            S_CAPTURE: begin
                state_d = S_SEND;
                data_d  = rq_q;
            end
            S_SEND: state_d = data_wanted[grant_q] ? S_IDLE : S_SEND;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rq_re      = state_q == S_POP;
        busy       = state_q != S_IDLE;
        data_ready = (state_q == S_SEND) ? (N'(1) << grant_q) : '0;
        data       = data_q;
        grant_id   = grant_q;
    end

`ifdef RQ_ARB_STATS_EN
    logic [15:0] pop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pop_q <= '0;
        else if (rq_re && pop_q != 16'hFFFF) pop_q <= pop_q + 16'd1;
    end

    assign pop_count = pop_q;
`endif
endmodule
